// File: rtl/tick_pkg.sv
// Shared constants for the slow-clock tick receiver.
package tick_pkg;

  // Default width of the gap counter and period measurement.
  localparam int CNT_W_DEFAULT = 28;

  // The clock divider toggles its output every 125000 clk cycles,
  // so one full slow-clock period is 250000 clk cycles.
  localparam int DIV_HALF_PERIOD = 125000;
  localparam int SLOW_PERIOD     = 2 * DIV_HALF_PERIOD;

  // The watchdog fires 20% past one nominal period.
  localparam int TIMEOUT_MARGIN  = SLOW_PERIOD / 5;
  localparam int TIMEOUT_DEFAULT = SLOW_PERIOD + TIMEOUT_MARGIN;

  // Width of a counter that runs 0..ticks-1. It is never narrower than 1 bit.
  function automatic int tick_cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous level, plus a registered
// rising-edge strobe. After reset an edge counts only once a low level
// has been seen through the flushed chain. This stops a level that is
// already high from looking like a fresh edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [SYNC_STAGES-1:0] flush_reg;
  logic [SYNC_STAGES-1:0] flush_next;
  logic                   prev_reg;
  logic                   low_seen_reg;
  logic                   low_seen_next;
  logic                   rise_reg;
  logic                   rise_next;
  logic                   sync_last;

  // Stage 0 samples the pin. Later stages shift down the chain. The flush
  // marker moves in step with the chain, so its top bit shows that the last
  // stage holds a real sample and not the reset value.
  assign sync_next[0]  = async_in;
  assign flush_next[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign sync_next[gi]  = sync_reg[gi-1];
      assign flush_next[gi] = flush_reg[gi-1];
    end
  endgenerate

  assign sync_last     = sync_reg[SYNC_STAGES-1];
  assign low_seen_next = low_seen_reg | (flush_reg[SYNC_STAGES-1] & ~sync_last);
  assign rise_next     = low_seen_reg & sync_last & ~prev_reg;
  assign rise          = rise_reg;

  // Registers for the synchronizer chain, edge history and registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= '0;
      flush_reg    <= '0;
      prev_reg     <= 1'b0;
      low_seen_reg <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      sync_reg     <= sync_next;
      flush_reg    <= flush_next;
      prev_reg     <= sync_last;
      low_seen_reg <= low_seen_next;
      rise_reg     <= rise_next;
    end
  end

endmodule

// File: rtl/clk_tick_receiver.sv
// Turns the divided slow clock back into fast-domain timing: tick per slow
// rising edge, an event strobe every TICKS_PER_EVENT ticks, slow-period
// measurement and a loss-of-clock watchdog.
// The event output is named event_strobe because "event" is a reserved word.
module clk_tick_receiver
  import tick_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int TICKS_PER_EVENT = 16,
  parameter int TIMEOUT         = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             clear,
  output logic             tick,
  output logic             event_strobe,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  localparam int                TCNT_W    = tick_cnt_width(TICKS_PER_EVENT);
  localparam logic [CNT_W-1:0]  GAP_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_EVENT - 1);

  logic              rise;
  logic              lost;
  logic [CNT_W-1:0]  gap_inc;

  logic [CNT_W-1:0]  gap_reg,    gap_next;
  logic [TCNT_W-1:0] tcnt_reg,   tcnt_next;
  logic              armed_reg,  armed_next;
  logic [CNT_W-1:0]  period_reg, period_next;
  logic              pv_reg,     pv_next;
  logic              to_reg,     to_next;
  logic              tick_reg,   tick_next;
  logic              event_reg,  event_next;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (slow_clk),
    .rise     (rise)
  );

  // Saturating increment. It feeds both the free-running gap counter and the
  // period capture, so a long gap can never wrap to a small value.
  assign gap_inc = (gap_reg == GAP_MAX) ? GAP_MAX : gap_reg + 1'b1;
  assign lost    = (gap_reg >= TIMEOUT_C);

  // Next state for the counters, measurement and watchdog. A clear beats a
  // coincident rise for all state, but the tick itself is still emitted.
  always_comb begin
    gap_next    = gap_inc;
    tcnt_next   = tcnt_reg;
    armed_next  = armed_reg;
    period_next = period_reg;
    pv_next     = pv_reg;
    to_next     = to_reg;
    tick_next   = rise;
    event_next  = 1'b0;

    if (clear) begin
      gap_next   = '0;
      tcnt_next  = '0;
      armed_next = 1'b0;
      pv_next    = 1'b0;
      to_next    = 1'b0;
    end else begin
      if (lost) begin
        to_next    = 1'b1;
        pv_next    = 1'b0;
        armed_next = 1'b0;
      end
      if (rise) begin
        gap_next   = '0;
        to_next    = 1'b0;
        armed_next = 1'b1;
        // A rise after a timeout only re-arms. It does not measure.
        if (armed_reg && !lost) begin
          period_next = gap_inc;
          pv_next     = 1'b1;
        end
        if (tcnt_reg == TCNT_LAST) begin
          tcnt_next  = '0;
          event_next = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
    end
  end

  // State register. Reset overrides everything, including clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_reg    <= '0;
      tcnt_reg   <= '0;
      armed_reg  <= 1'b0;
      period_reg <= '0;
      pv_reg     <= 1'b0;
      to_reg     <= 1'b0;
      tick_reg   <= 1'b0;
      event_reg  <= 1'b0;
    end else begin
      gap_reg    <= gap_next;
      tcnt_reg   <= tcnt_next;
      armed_reg  <= armed_next;
      period_reg <= period_next;
      pv_reg     <= pv_next;
      to_reg     <= to_next;
      tick_reg   <= tick_next;
      event_reg  <= event_next;
    end
  end

  assign tick         = tick_reg;
  assign event_strobe = event_reg;
  assign period       = period_reg;
  assign period_valid = pv_reg;
  assign timeout      = to_reg;

endmodule
